// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared geometry, row type and stream FSM encoding for the
//               matrix TX streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int ELEM_W         = 8;
    localparam int MAX_SIZE       = 32;
    localparam int ROW_W          = MAX_SIZE * ELEM_W;
    localparam int DIBITS_PER_ROW = MAX_SIZE * ELEM_W / 2;
    localparam int DCNT_W         = $clog2(DIBITS_PER_ROW);
    localparam int ROWCNT_W       = $clog2(MAX_SIZE) + 1;

    typedef logic [ROW_W-1:0]    row_t;
    typedef logic [DCNT_W-1:0]   dcnt_t;
    typedef logic [ROWCNT_W-1:0] rowcnt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } stream_state_t;

    localparam dcnt_t   c_LAST_DIBIT     = dcnt_t'(DIBITS_PER_ROW - 1);
    localparam rowcnt_t c_ROWS_PER_FRAME = rowcnt_t'(MAX_SIZE);

    // Element 0 sits at the top of the row, so its MSB dibit leaves first.
    function automatic logic [1:0] top_dibit(input row_t r);
        return r[ROW_W-1 -: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : row_fifo2
// Description : Two-entry in-order row buffer with occupancy, flush and
//               same-cycle push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module row_fifo2 import matrix_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       push_i,
    input  row_t       data_i,
    input  logic       pop_i,
    output row_t       data_o,
    output logic [1:0] occ_o,
    output logic       empty_o
);

    row_t       mem_q [2];
    logic       wr_ptr_q;
    logic       wr_ptr_d;
    logic       rd_ptr_q;
    logic       rd_ptr_d;
    logic [1:0] occ_q;
    logic [1:0] occ_d;
    logic       w_push;
    logic       w_pop;

    assign w_push = push_i && !flush_i && (occ_q != 2'd2);
    assign w_pop  = pop_i  && !flush_i && (occ_q != 2'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (w_push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;
    assign empty_o = (occ_q == 2'd0);

endmodule
`default_nettype wire

// File: rtl/matrix_streamer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_streamer
// Description : Serialises MAX_SIZE result rows per frame into a 2-bit
//               axiov/axiod stream for the Ethernet TX path.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_streamer import matrix_pkg::*; (
    input  logic       eth_refclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       row_valid,
    output logic       row_ready,
    input  row_t       row_data,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       busy,
    output logic       done
);

    stream_state_t state_q;
    stream_state_t state_d;
    rowcnt_t       rows_acc_q;
    rowcnt_t       rows_acc_d;
    rowcnt_t       rows_sent_q;
    rowcnt_t       rows_sent_d;
    row_t          sh_data_q;
    row_t          sh_data_d;
    logic          sh_valid_q;
    logic          sh_valid_d;
    dcnt_t         dcnt_q;
    dcnt_t         dcnt_d;

    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_fifo_empty;
    logic [1:0]    w_fifo_occ;
    row_t          w_fifo_head;
    logic          w_row_ready;
    logic          w_last_dibit;

    row_fifo2 u_row_fifo (
        .clk     (eth_refclk),
        .rst_n   (rst_n),
        .flush_i (w_flush),
        .push_i  (w_push),
        .data_i  (row_data),
        .pop_i   (w_pop),
        .data_o  (w_fifo_head),
        .occ_o   (w_fifo_occ),
        .empty_o (w_fifo_empty)
    );

    assign w_row_ready  = (state_q == ACTIVE) && (w_fifo_occ != 2'd2) &&
                          (rows_acc_q < c_ROWS_PER_FRAME);
    assign w_last_dibit = sh_valid_q && (dcnt_q == c_LAST_DIBIT);

    always_ff @(posedge eth_refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rows_acc_q  <= '0;
            rows_sent_q <= '0;
            sh_data_q   <= '0;
            sh_valid_q  <= 1'b0;
            dcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            rows_acc_q  <= rows_acc_d;
            rows_sent_q <= rows_sent_d;
            sh_data_q   <= sh_data_d;
            sh_valid_q  <= sh_valid_d;
            dcnt_q      <= dcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rows_acc_d  = rows_acc_q;
        rows_sent_d = rows_sent_q;
        sh_data_d   = sh_data_q;
        sh_valid_d  = sh_valid_q;
        dcnt_d      = dcnt_q;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ACTIVE;
                    rows_acc_d  = '0;
                    rows_sent_d = '0;
                    sh_valid_d  = 1'b0;
                    dcnt_d      = '0;
                    w_flush     = 1'b1;
                end
            end

            ACTIVE: begin
                if (abort) begin
                    // Abort wins over any row offered this cycle; it is dropped.
                    state_d    = IDLE;
                    sh_data_d  = '0;
                    sh_valid_d = 1'b0;
                    dcnt_d     = '0;
                    w_flush    = 1'b1;
                end else begin
                    w_push = row_valid && w_row_ready;
                    if (w_push) begin
                        rows_acc_d = rows_acc_q + rowcnt_t'(1);
                    end

                    if (sh_valid_q) begin
                        sh_data_d = sh_data_q << 2;
                        dcnt_d    = dcnt_q + dcnt_t'(1);
                    end

                    if (w_last_dibit) begin
                        rows_sent_d = rows_sent_q + rowcnt_t'(1);
                        sh_valid_d  = 1'b0;
                        dcnt_d      = '0;
                        if (rows_sent_q == c_ROWS_PER_FRAME - rowcnt_t'(1)) begin
                            state_d = DONE;
                        end
                    end

                    // Reloading on the last dibit keeps back-to-back rows gapless.
                    if ((!sh_valid_q || w_last_dibit) && !w_fifo_empty) begin
                        w_pop      = 1'b1;
                        sh_data_d  = w_fifo_head;
                        sh_valid_d = 1'b1;
                        dcnt_d     = '0;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign row_ready = w_row_ready;
    assign axiov     = sh_valid_q;
    assign axiod     = sh_valid_q ? top_dibit(sh_data_q) : 2'b00;
    assign busy      = (state_q == ACTIVE);
    assign done      = (state_q == DONE);

endmodule
`default_nettype wire
